// File: rtl/neighbor_builder.sv
// Builds the per-vertex neighbor table in RAM_NBR from the triangle list in RAM_OBJ.
// Slot v (0-based) holds a count word followed by unique 1-based neighbor indices in first-insertion order.
module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] vertex_count,
    input  logic [31:0] face_count,
    input  logic [31:0] RAM_OBJ_Do,
    input  logic [31:0] RAM_NBR_Do,
    output logic        RAM_OBJ_EN,
    output logic [8:0]  RAM_OBJ_A,
    output logic [3:0]  RAM_OBJ_WE,
    output logic [31:0] RAM_OBJ_Di,
    output logic        RAM_NBR_EN,
    output logic [8:0]  RAM_NBR_A,
    output logic [3:0]  RAM_NBR_WE,
    output logic [31:0] RAM_NBR_Di,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        bad_index
);

    localparam logic [31:0] MAX_W  = 32'(MAX_NEIGHBOR_COUNT);
    localparam logic [31:0] FULL_W = 32'(MAX_NEIGHBOR_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, FACE_RD, EDGE_CNT, EDGE_SCAN, EDGE_WR, CNT_WR, DONE
    } state_t;

    state_t      state, state_d;
    logic [1:0]  phase, phase_d;
    logic [2:0]  edge_idx, edge_d;
    logic [31:0] v_reg, v_d, f_reg, f_d, f_idx, f_idx_d, clr_idx, clr_d;
    logic [31:0] a, a_d, b, b_d, c, c_d, cnt, cnt_d, scan_i, scan_d;
    logic        overflow_d, bad_d;

    logic [31:0] u, w, base, cnt_cur;
    logic        no_match, edge_end, face_end;

    function automatic logic idx_ok(input logic [31:0] x, input logic [31:0] lim);
        return (x != 32'd0) && (x <= lim);
    endfunction

    always_comb begin
        unique case (edge_idx)
            3'd0:    begin u = a; w = b; end
            3'd1:    begin u = a; w = c; end
            3'd2:    begin u = b; w = a; end
            3'd3:    begin u = b; w = c; end
            3'd4:    begin u = c; w = a; end
            default: begin u = c; w = b; end
        endcase
    end

    assign base    = (u - 32'd1) * MAX_W;
    assign cnt_cur = (state == EDGE_CNT) ? RAM_NBR_Do : cnt;

    // NOTE: outputs are decoded from state, so the asynchronous reset of state drops WE/EN/busy in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            edge_idx  <= '0;
            v_reg     <= '0;
            f_reg     <= '0;
            f_idx     <= '0;
            clr_idx   <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            cnt       <= '0;
            scan_i    <= '0;
            overflow  <= 1'b0;
            bad_index <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            edge_idx  <= edge_d;
            v_reg     <= v_d;
            f_reg     <= f_d;
            f_idx     <= f_idx_d;
            clr_idx   <= clr_d;
            a         <= a_d;
            b         <= b_d;
            c         <= c_d;
            cnt       <= cnt_d;
            scan_i    <= scan_d;
            overflow  <= overflow_d;
            bad_index <= bad_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state;
        phase_d    = phase;
        edge_d     = edge_idx;
        v_d        = v_reg;
        f_d        = f_reg;
        f_idx_d    = f_idx;
        clr_d      = clr_idx;
        a_d        = a;
        b_d        = b;
        c_d        = c;
        cnt_d      = cnt;
        scan_d     = scan_i;
        overflow_d = overflow;
        bad_d      = bad_index;
        no_match   = 1'b0;
        edge_end   = 1'b0;
        face_end   = 1'b0;
        RAM_OBJ_EN = 1'b0;
        RAM_OBJ_A  = '0;
        RAM_OBJ_WE = '0;
        RAM_OBJ_Di = '0;
        RAM_NBR_EN = 1'b0;
        RAM_NBR_A  = '0;
        RAM_NBR_WE = '0;
        RAM_NBR_Di = '0;
        busy       = (state != IDLE) && (state != DONE);
        done       = 1'b0;

        unique case (state)
            IDLE: if (start) begin
                v_d        = vertex_count;
                f_d        = face_count;
                f_idx_d    = '0;
                clr_d      = '0;
                phase_d    = '0;
                overflow_d = 1'b0;
                bad_d      = 1'b0;
                state_d    = (vertex_count == 32'd0) ? DONE : CLEAR;
            end
            CLEAR: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'b1111;
                RAM_NBR_A  = 9'(clr_idx * MAX_W);
                clr_d      = clr_idx + 32'd1;
                if (clr_idx + 32'd1 == v_reg)
                    state_d = (f_reg == 32'd0) ? DONE : FACE_RD;
            end
            FACE_RD: begin
                if (phase != 2'd3) begin
                    RAM_OBJ_EN = 1'b1;
                    RAM_OBJ_A  = 9'(32'd3 * v_reg + 32'd3 * f_idx + {30'd0, phase});
                end
                phase_d = phase + 2'd1;
                unique case (phase)
                    2'd1: a_d = RAM_OBJ_Do;
                    2'd2: b_d = RAM_OBJ_Do;
                    2'd3: begin
                        c_d = RAM_OBJ_Do;
                        if (idx_ok(a, v_reg) && idx_ok(b, v_reg) && idx_ok(RAM_OBJ_Do, v_reg)) begin
                            state_d = EDGE_CNT;
                            edge_d  = '0;
                            phase_d = '0;
                        end else begin
                            bad_d    = 1'b1;
                            face_end = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            EDGE_CNT: begin
                if (phase == 2'd0) begin
                    if (u == w) begin
                        edge_end = 1'b1;
                    end else begin
                        RAM_NBR_EN = 1'b1;
                        RAM_NBR_A  = 9'(base);
                        phase_d    = 2'd1;
                    end
                end else begin
                    cnt_d = RAM_NBR_Do;
                    if (RAM_NBR_Do == 32'd0) begin
                        no_match = 1'b1;
                    end else begin
                        RAM_NBR_EN = 1'b1;
                        RAM_NBR_A  = 9'(base + 32'd1);
                        scan_d     = 32'd1;
                        state_d    = EDGE_SCAN;
                    end
                end
            end
            EDGE_SCAN: begin
                if (RAM_NBR_Do == w) begin
                    edge_end = 1'b1;
                end else if (scan_i == cnt) begin
                    no_match = 1'b1;
                end else begin
                    RAM_NBR_EN = 1'b1;
                    RAM_NBR_A  = 9'(base + scan_i + 32'd1);
                    scan_d     = scan_i + 32'd1;
                end
            end
            EDGE_WR: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'b1111;
                RAM_NBR_A  = 9'(base + cnt + 32'd1);
                RAM_NBR_Di = w;
                state_d    = CNT_WR;
            end
            CNT_WR: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'b1111;
                RAM_NBR_A  = 9'(base);
                RAM_NBR_Di = cnt + 32'd1;
                edge_end   = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A full slot with no duplicate drops the edge rather than writing past the slot.
        if (no_match) begin
            if (cnt_cur >= FULL_W) begin
                overflow_d = 1'b1;
                edge_end   = 1'b1;
            end else begin
                state_d = EDGE_WR;
            end
        end
        if (edge_end) begin
            if (edge_idx == 3'd5) begin
                face_end = 1'b1;
            end else begin
                edge_d  = edge_idx + 3'd1;
                state_d = EDGE_CNT;
                phase_d = '0;
            end
        end
        if (face_end) begin
            f_idx_d = f_idx + 32'd1;
            phase_d = '0;
            state_d = (f_idx + 32'd1 == f_reg) ? DONE : FACE_RD;
        end
    end

endmodule

// File: tb/tb_neighbor_builder.sv
// Directed bench for neighbor_builder: two instances (slot sizes 10 and 4) with behavioural RAMs.
module tb_neighbor_builder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start4;
    logic [31:0] vertex_count, face_count;

    logic        obj_en, nbr_en, busy, done, overflow, bad_index;
    logic [8:0]  obj_a, nbr_a;
    logic [3:0]  obj_we, nbr_we;
    logic [31:0] obj_di, nbr_di, obj_do, nbr_do;

    logic        obj_en4, nbr_en4, busy4, done4, overflow4, bad_index4;
    logic [8:0]  obj_a4, nbr_a4;
    logic [3:0]  obj_we4, nbr_we4;
    logic [31:0] obj_di4, nbr_di4, obj_do4, nbr_do4;

    logic [31:0] obj_mem [512];
    logic [31:0] nbr_mem [512];
    logic [31:0] nbr4_mem [512];
    logic        fill_go = 1'b0;
    logic [31:0] fill_val = '0;
    int          nbr_writes = 0;

    int tests = 0;
    int fails = 0;

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(obj_do), .RAM_NBR_Do(nbr_do),
        .RAM_OBJ_EN(obj_en), .RAM_OBJ_A(obj_a), .RAM_OBJ_WE(obj_we), .RAM_OBJ_Di(obj_di),
        .RAM_NBR_EN(nbr_en), .RAM_NBR_A(nbr_a), .RAM_NBR_WE(nbr_we), .RAM_NBR_Di(nbr_di),
        .busy(busy), .done(done), .overflow(overflow), .bad_index(bad_index)
    );

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(obj_do4), .RAM_NBR_Do(nbr_do4),
        .RAM_OBJ_EN(obj_en4), .RAM_OBJ_A(obj_a4), .RAM_OBJ_WE(obj_we4), .RAM_OBJ_Di(obj_di4),
        .RAM_NBR_EN(nbr_en4), .RAM_NBR_A(nbr_a4), .RAM_NBR_WE(nbr_we4), .RAM_NBR_Di(nbr_di4),
        .busy(busy4), .done(done4), .overflow(overflow4), .bad_index(bad_index4)
    );

    always @(posedge clk) begin
        if (obj_en)  obj_do  <= obj_mem[obj_a];
        if (obj_en4) obj_do4 <= obj_mem[obj_a4];
        if (fill_go) begin
            for (int i = 0; i < 512; i++) nbr_mem[i] <= fill_val;
        end else if (nbr_en) begin
            if (nbr_we != 4'd0) begin
                nbr_mem[nbr_a] <= nbr_di;
                nbr_writes     <= nbr_writes + 1;
            end else begin
                nbr_do <= nbr_mem[nbr_a];
            end
        end
        if (nbr_en4) begin
            if (nbr_we4 != 4'd0) nbr4_mem[nbr_a4] <= nbr_di4;
            else                 nbr_do4 <= nbr4_mem[nbr_a4];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_face(input int v, input int f, input int ia, input int ib, input int ic);
        obj_mem[3*v + 3*f + 0] = 32'(ia);
        obj_mem[3*v + 3*f + 1] = 32'(ib);
        obj_mem[3*v + 3*f + 2] = 32'(ic);
    endtask

    task automatic fill(input logic [31:0] val);
        @(negedge clk);
        fill_val = val;
        fill_go  = 1'b1;
        @(negedge clk);
        fill_go  = 1'b0;
    endtask

    // Pulses start for one cycle and counts negedges until done; cyc is start-to-done latency.
    task automatic run(input bit use4, input logic [31:0] v, input logic [31:0] f,
                       input string tag, output int cyc);
        logic seen;
        seen = 1'b0;
        vertex_count = v;
        face_count   = f;
        @(negedge clk);
        if (use4) start4 = 1'b1;
        else      start  = 1'b1;
        cyc = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            start  = 1'b0;
            start4 = 1'b0;
            cyc++;
            if (cyc == 1) check({tag, "_busy"}, use4 ? busy4 : busy, 1'b1);
            seen = use4 ? done4 : done;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        @(negedge clk);
        check({tag, "_done_pulse"}, use4 ? done4 : done, 1'b0);
        check({tag, "_idle_busy"}, use4 ? busy4 : busy, 1'b0);
    endtask

    task automatic slot(input string tag, input int addr, input int n, input int w0,
                        input int w1, input int w2, input int w3);
        int exp [4];
        exp = '{w0, w1, w2, w3};
        for (int i = 0; i < n; i++)
            check($sformatf("%s_w%0d", tag, i), nbr_mem[addr + i], 32'(exp[i]));
    endtask

    initial begin
        int cyc, wr0;
        logic found;
        rst = 1'b1; start = 1'b0; start4 = 1'b0;
        vertex_count = '0; face_count = '0;
        for (int i = 0; i < 512; i++) obj_mem[i] = '0;
        repeat (2) @(negedge clk);

        // Outputs held at zero under reset.
        check("rst_obj_en", obj_en, 1'b0);
        check("rst_nbr_en", nbr_en, 1'b0);
        check("rst_nbr_we", nbr_we, 4'd0);
        check("rst_nbr_a",  nbr_a, 9'd0);
        check("rst_nbr_di", nbr_di, 32'd0);
        check("rst_busy",   busy, 1'b0);
        check("rst_done",   done, 1'b0);
        check("rst_flags",  {overflow, bad_index, overflow4, bad_index4}, 4'd0);
        rst = 1'b0;
        fill(32'd0);

        // V=3, F=1, face (1,2,3).
        set_face(3, 0, 1, 2, 3);
        run(1'b0, 3, 1, "tri", cyc);
        slot("tri_s0", 0,  3, 2, 2, 3, 0);
        slot("tri_s1", 10, 3, 2, 1, 3, 0);
        slot("tri_s2", 20, 3, 2, 1, 2, 0);
        check("tri_flags", {overflow, bad_index}, 2'b00);
        check("tri_obj_we", obj_we, 4'd0);

        // V=4, F=2, shared edge 1-3 stored once.
        set_face(4, 0, 1, 2, 3);
        set_face(4, 1, 1, 3, 4);
        run(1'b0, 4, 2, "quad", cyc);
        slot("quad_s0", 0,  4, 3, 2, 3, 4);
        slot("quad_s1", 10, 3, 2, 1, 3, 0);
        slot("quad_s2", 20, 4, 3, 1, 2, 4);
        slot("quad_s3", 30, 3, 2, 1, 3, 0);

        // Slot size 4: vertex 1 sees 2,3,4,5 but only three fit.
        set_face(5, 0, 1, 2, 3);
        set_face(5, 1, 1, 4, 5);
        run(1'b1, 5, 2, "ovf", cyc);
        check("ovf_s0_cnt", nbr4_mem[0], 32'd3);
        check("ovf_s0_w1",  nbr4_mem[1], 32'd2);
        check("ovf_s0_w2",  nbr4_mem[2], 32'd3);
        check("ovf_s0_w3",  nbr4_mem[3], 32'd4);
        check("ovf_s4_cnt", nbr4_mem[16], 32'd2);
        check("ovf_flag",   overflow4, 1'b1);
        check("ovf_bad",    bad_index4, 1'b0);

        // Index 5 with V=3: face skipped, only CLEAR writes.
        set_face(3, 0, 1, 5, 2);
        wr0 = nbr_writes;
        run(1'b0, 3, 1, "bad", cyc);
        check("bad_flag",   bad_index, 1'b1);
        check("bad_writes", 32'(nbr_writes - wr0), 32'd3);
        check("bad_s0_cnt", nbr_mem[0], 32'd0);

        // F=0 over a prefilled table: only count words change, latency V+1.
        fill(32'hFFFF_FFFF);
        run(1'b0, 4, 0, "empty", cyc);
        check("empty_latency", 32'(cyc), 32'd5);
        check("empty_c0",  nbr_mem[0],  32'd0);
        check("empty_c10", nbr_mem[10], 32'd0);
        check("empty_c20", nbr_mem[20], 32'd0);
        check("empty_c30", nbr_mem[30], 32'd0);
        check("empty_w1",  nbr_mem[1],  32'hFFFF_FFFF);
        check("empty_w40", nbr_mem[40], 32'hFFFF_FFFF);
        check("empty_bad_cleared", bad_index, 1'b0);

        // Face (1,1,2): self edges skipped, duplicates dropped.
        set_face(3, 0, 1, 1, 2);
        run(1'b0, 3, 1, "self", cyc);
        slot("self_s0", 0,  2, 1, 2, 0, 0);
        slot("self_s1", 10, 2, 1, 1, 0, 0);
        check("self_s2_cnt", nbr_mem[20], 32'd0);
        check("self_flags", {overflow, bad_index}, 2'b00);

        // Reset while a neighbor word is being written, then rebuild.
        set_face(4, 0, 1, 2, 3);
        set_face(4, 1, 1, 3, 4);
        vertex_count = 32'd4;
        face_count   = 32'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (nbr_we == 4'hF && (nbr_a % 9'd10) != 9'd0) found = 1'b1;
            else @(negedge clk);
        end
        check("midrst_found_edge_wr", found, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst_we",   nbr_we, 4'd0);
        check("midrst_en",   nbr_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        fill(32'hFFFF_FFFF);
        run(1'b0, 4, 2, "rebuild", cyc);
        slot("rebuild_s0", 0,  4, 3, 2, 3, 4);
        slot("rebuild_s2", 20, 4, 3, 1, 2, 4);
        slot("rebuild_s3", 30, 3, 2, 1, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
